// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM encoding, register map and STATUS bit indices for mmio_uart_tx
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Register offsets relative to BASE_ADDR
    localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFF = 32'h0000_0004;

    // STATUS register bit positions
    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_OVERRUN_BIT = 1;
    localparam int STATUS_FULL_BIT    = 2;

    // Depth of the pending queue when the FIFO build option is enabled
    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - processor store/load bus bundle for the MMIO UART transmitter
// Signals:
//   write_enable_i - store strobe (master -> slave)
//   Address_i      - 32-bit byte address (master -> slave)
//   Write_Data     - 32-bit store data (master -> slave)
//   Read_Data_o    - 32-bit combinational load data (slave -> master)
interface mmio_uart_tx_if;
    logic        write_enable_i;
    logic [31:0] Address_i;
    logic [31:0] Write_Data;
    logic [31:0] Read_Data_o;

    modport master (
        output write_enable_i,
        output Address_i,
        output Write_Data,
        input  Read_Data_o
    );

    modport slave (
        input  write_enable_i,
        input  Address_i,
        input  Write_Data,
        output Read_Data_o
    );
endinterface

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter 0..CLKS_PER_BIT-1 with terminal-count tick
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset, counter returns to 0
//   clear_i  - synchronous clear to 0 (takes priority over enable_i)
//   enable_i - count while high
//   tick_o   - high during the last cycle of a bit period (count == CLKS_PER_BIT-1)
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            // Wrap on the tick so back-to-back bit periods need no extra clear
            cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TXDATA/STATUS registers
// Build option: define UART_TX_FIFO_EN for a 4-entry pending FIFO; otherwise a single
// holding register is used.
// Ports:
//   clk            - system clock, rising edge
//   reset          - asynchronous active-high reset
//   write_enable_i - processor store strobe
//   Address_i      - processor byte address, fully decoded
//   Write_Data     - store data; [7:0] to TXDATA, [1] clears overrun at STATUS
//   Read_Data_o    - combinational load data, STATUS = {29'b0, full, overrun, busy}
//   tx_o           - registered serial line, idle high
//   busy_o         - frame shifting or byte pending
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data,
    output logic [31:0] Read_Data_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFF;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFF;

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        ovr_q, ovr_d;

    logic        wr_txdata;
    logic        wr_status;
    logic        q_empty;
    logic        q_full;
    logic [7:0]  q_head;
    logic        pop;
    logic        push;
    logic        baud_tick;

    logic        unused_wdata;
    assign unused_wdata = ^Write_Data[31:8];

    assign wr_txdata = write_enable_i && (Address_i == TXDATA_ADDR);
    assign wr_status = write_enable_i && (Address_i == STATUS_ADDR);

    // A full queue still takes a write on the edge that frees a slot by popping
    assign push = wr_txdata && (!q_full || pop);

    //------------------------------------------------------------------
    // Pending queue
    //------------------------------------------------------------------
`ifdef UART_TX_FIFO_EN
    logic [7:0] fifo_q [FIFO_DEPTH];
    logic [7:0] fifo_d [FIFO_DEPTH];
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] count_q, count_d;

    assign q_empty = (count_q == 3'd0);
    assign q_full  = (count_q == 3'(FIFO_DEPTH));
    assign q_head  = fifo_q[rd_ptr_q];

    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            // When full and popping, wr_ptr equals rd_ptr; the head is read
            // combinationally this cycle so overwriting the slot is safe.
            fifo_d[wr_ptr_q] = Write_Data[7:0];
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_q   <= fifo_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;

    assign q_empty = !hold_valid_q;
    assign q_full  = hold_valid_q;
    assign q_head  = hold_q;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (pop) begin
            hold_valid_d = 1'b0;
        end
        // Push after pop so a same-edge refill leaves the register valid
        if (push) begin
            hold_d       = Write_Data[7:0];
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    //------------------------------------------------------------------
    // Bit timing
    //------------------------------------------------------------------
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == ST_IDLE),
        .enable_i (state_q != ST_IDLE),
        .tick_o   (baud_tick)
    );

    //------------------------------------------------------------------
    // Transmit FSM
    //------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop       = 1'b1;
                    shift_d   = q_head;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (!q_empty) begin
                        // Chain straight into the next start bit, no idle cycle
                        pop       = 1'b1;
                        shift_d   = q_head;
                        bit_idx_d = '0;
                        tx_d      = 1'b0;
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ovr_d = ovr_q;
        if (wr_txdata && q_full && !pop) begin
            ovr_d = 1'b1;
        end else if (wr_status && Write_Data[STATUS_OVERRUN_BIT]) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            ovr_q     <= ovr_d;
        end
    end

    //------------------------------------------------------------------
    // Outputs and register read
    //------------------------------------------------------------------
    assign tx_o   = tx_q;
    assign busy_o = (state_q != ST_IDLE) || !q_empty;

    always_comb begin
        Read_Data_o = '0;
        if (Address_i == STATUS_ADDR) begin
            Read_Data_o[STATUS_BUSY_BIT]    = busy_o;
            Read_Data_o[STATUS_OVERRUN_BIT] = ovr_q;
            Read_Data_o[STATUS_FULL_BIT]    = q_full;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized self-checking bench for mmio_uart_tx with a frame-level reference model
module tb_mmio_uart_tx;

    localparam int          C    = 4;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [31:0] STAT = 32'h1001_0004;
    localparam logic [31:0] BAD  = 32'h1001_0008;
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic tx_o;
    logic busy_o;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .write_enable_i (bus.write_enable_i),
        .Address_i      (bus.Address_i),
        .Write_Data     (bus.Write_Data),
        .Read_Data_o    (bus.Read_Data_o),
        .tx_o           (tx_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes waiting, and the frame currently on the line
    // described by its start edge and the edge at which the line is free again.
    logic [7:0]  m_pend[$];
    logic [7:0]  m_byte;
    int          m_start;
    int          m_end;
    logic        m_ovr;
    logic        m_tx;
    logic        m_busy;
    logic [31:0] m_status;
    int          k = 0;

    task automatic m_outputs();
        int pos;
        if (k < m_end) begin
            pos = (k - m_start) / C;
            if (pos == 0)      m_tx = 1'b0;
            else if (pos == 9) m_tx = 1'b1;
            else               m_tx = m_byte[pos-1];
        end else begin
            m_tx = 1'b1;
        end
        m_busy   = (k < m_end) || (m_pend.size() > 0);
        m_status = {29'b0, (m_pend.size() == DEPTH), m_ovr, m_busy};
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_start = k;
        m_end   = k;
        m_ovr   = 1'b0;
        m_byte  = '0;
        m_outputs();
    endtask

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic popping;
        logic full;
        logic accept;
        popping = (m_pend.size() > 0) && (k >= m_end);
        full    = (m_pend.size() == DEPTH);
        accept  = 1'b0;
        if (we && a == BASE) begin
            if (!full || popping) accept = 1'b1;
            else                  m_ovr  = 1'b1;
        end
        if (we && a == STAT && d[1]) m_ovr = 1'b0;
        if (popping) begin
            m_byte  = m_pend.pop_front();
            m_start = k;
            m_end   = k + 10 * C;
        end
        if (accept) m_pend.push_back(d[7:0]);
        m_outputs();
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return (a == STAT) ? m_status : 32'h0;
    endfunction

    // Drive one cycle of bus stimulus, advance the model over the edge,
    // and leave time 1 unit after the edge for sampling.
    task automatic tick(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.write_enable_i = we;
        bus.Address_i      = a;
        bus.Write_Data     = d;
        @(posedge clk);
        k++;
        if (reset) model_reset();
        else       model_edge(we, a, d);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, STAT, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 32'h0);
        checks++;
        if ({tx_o, busy_o} !== 2'b10) begin
            failures++;
            $display("FAIL reset_hold tx,busy got=%b exp=10", {tx_o, busy_o});
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 32'h0, 32'h0);
            checks++;
            if ({tx_o, busy_o} !== {m_tx, m_busy}) begin
                failures++;
                $display("FAIL reset_idle k=%0d tx,busy got=%b exp=%b", k, {tx_o, busy_o}, {m_tx, m_busy});
            end
        end
        bus.Address_i = STAT;
        #1;
        checks++;
        if (bus.Read_Data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_status got=%h exp=%h", bus.Read_Data_o, 32'h0);
        end
        bus.Address_i = BASE;
        #1;
        checks++;
        if (bus.Read_Data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_txdata_read got=%h exp=%h", bus.Read_Data_o, 32'h0);
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] pat;
        pat = {1'b1, 8'h55, 1'b0};
        tick(1'b1, BASE, 32'h0000_0055);
        for (int j = 1; j <= 45; j++) begin
            tick(1'b0, STAT, 32'h0);
            checks++;
            if ({tx_o, busy_o} !== {m_tx, m_busy} ||
                tx_o !== ((j <= 40) ? pat[(j-1)/C] : 1'b1) ||
                busy_o !== (j < 41)) begin
                failures++;
                $display("FAIL frame55 j=%0d tx,busy got=%b exp=%b", j, {tx_o, busy_o}, {m_tx, m_busy});
            end
            checks++;
            if (bus.Read_Data_o !== m_read(STAT)) begin
                failures++;
                $display("FAIL frame55_status j=%0d got=%h exp=%h", j, bus.Read_Data_o, m_read(STAT));
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, BASE, 32'h0000_00A3);
        tick(1'b1, BASE, 32'h0000_000F);
        for (int j = 0; j < 85; j++) begin
            tick(1'b0, STAT, 32'h0);
            checks++;
            if ({tx_o, busy_o} !== {m_tx, m_busy} || bus.Read_Data_o !== m_read(STAT)) begin
                failures++;
                $display("FAIL back_to_back j=%0d tx,busy got=%b exp=%b status got=%h exp=%h",
                         j, {tx_o, busy_o}, {m_tx, m_busy}, bus.Read_Data_o, m_read(STAT));
            end
        end
        checks++;
        if (busy_o !== 1'b0 || bus.Read_Data_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_end busy got=%b ovr got=%b exp=0,0", busy_o, bus.Read_Data_o[1]);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < DEPTH + 2; i++) tick(1'b1, BASE, 32'($urandom_range(0, 255)));
        bus.Address_i      = STAT;
        bus.write_enable_i = 1'b0;
        #1;
        checks++;
        if (bus.Read_Data_o !== 32'h7 || bus.Read_Data_o !== m_read(STAT)) begin
            failures++;
            $display("FAIL overrun_status got=%h exp=%h", bus.Read_Data_o, 32'h7);
        end
        tick(1'b1, STAT, 32'h0000_0002);
        checks++;
        if (bus.Read_Data_o[1] !== 1'b0 || bus.Read_Data_o !== m_read(STAT)) begin
            failures++;
            $display("FAIL overrun_clear got=%h exp=%h", bus.Read_Data_o, m_read(STAT));
        end
        for (int j = 0; j < 10 * C * (DEPTH + 1) + 4; j++) begin
            tick(1'b0, STAT, 32'h0);
            checks++;
            if ({tx_o, busy_o} !== {m_tx, m_busy} || bus.Read_Data_o !== m_read(STAT)) begin
                failures++;
                $display("FAIL overrun_drain j=%0d tx,busy got=%b exp=%b status got=%h exp=%h",
                         j, {tx_o, busy_o}, {m_tx, m_busy}, bus.Read_Data_o, m_read(STAT));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        tick(1'b1, BASE, 32'h0000_00F0);
        // 17 edges after the write puts the line in data bit 3 (a 0 for 0xF0)
        for (int j = 0; j < 17; j++) tick(1'b0, STAT, 32'h0);
        checks++;
        if (tx_o !== 1'b0 || m_tx !== 1'b0) begin
            failures++;
            $display("FAIL mid_frame_bit3 tx got=%b exp=0", tx_o);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({tx_o, busy_o} !== 2'b10 || bus.Read_Data_o !== 32'h0) begin
            failures++;
            $display("FAIL mid_frame_reset tx,busy got=%b exp=10 status got=%h exp=0", {tx_o, busy_o}, bus.Read_Data_o);
        end
        tick(1'b0, STAT, 32'h0);
        tick(1'b0, STAT, 32'h0);
        reset = 1'b0;
        tick(1'b1, BASE, 32'h0000_0081);
        for (int j = 0; j < 45; j++) begin
            tick(1'b0, STAT, 32'h0);
            checks++;
            if ({tx_o, busy_o} !== {m_tx, m_busy} || bus.Read_Data_o !== m_read(STAT)) begin
                failures++;
                $display("FAIL post_reset_frame j=%0d tx,busy got=%b exp=%b status got=%h exp=%h",
                         j, {tx_o, busy_o}, {m_tx, m_busy}, bus.Read_Data_o, m_read(STAT));
            end
        end
    endtask

    task automatic test_bad_addr();
        tick(1'b1, BAD, 32'h0000_0012);
        for (int j = 0; j < 45; j++) begin
            tick(1'b0, BAD, 32'h0);
            checks++;
            if ({tx_o, busy_o} !== 2'b10 || bus.Read_Data_o !== 32'h0) begin
                failures++;
                $display("FAIL bad_addr j=%0d tx,busy got=%b exp=10 read got=%h exp=0", j, {tx_o, busy_o}, bus.Read_Data_o);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addrs [3];
        int r;
        addrs[0] = BASE;
        addrs[1] = STAT;
        addrs[2] = BAD;
        for (int j = 0; j < 1500; j++) begin
            r = $urandom_range(0, 15);
            if (r < 3)       tick(1'b1, BASE, $urandom);
            else if (r == 3) tick(1'b1, STAT, $urandom);
            else if (r == 4) tick(1'b1, BAD, $urandom);
            else             tick(1'b0, addrs[$urandom_range(0, 2)], $urandom);
            checks++;
            if ({tx_o, busy_o} !== {m_tx, m_busy} || bus.Read_Data_o !== m_read(bus.Address_i)) begin
                failures++;
                $display("FAIL random k=%0d tx,busy got=%b exp=%b read got=%h exp=%h",
                         k, {tx_o, busy_o}, {m_tx, m_busy}, bus.Read_Data_o, m_read(bus.Address_i));
            end
        end
    endtask

    initial begin
        bus.write_enable_i = 1'b0;
        bus.Address_i      = 32'h0;
        bus.Write_Data     = 32'h0;
        reset              = 1'b1;
        model_reset();

        test_reset();
        test_single_frame();
        drain(4);
        test_back_to_back();
        drain(4);
        test_overrun();
        drain(4);
        test_reset_mid_frame();
        drain(4);
        test_bad_addr();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1001_0000: word address of the TXDATA register; STATUS is at BASE_ADDR+4.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434: clk cycles per serial bit (50 MHz / 115200).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1: system clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port write_enable_i, input, 1: processor store strobe.
REQ-007 SHALL have port Address_i, input, 32: processor byte address.
REQ-008 SHALL have port Write_Data, input, 32: store data; only [7:0] is used for TXDATA.
REQ-009 SHALL have port Read_Data_o, output, 32: combinational load data.
REQ-010 SHALL have port tx_o, output, 1: serial line, idle high, registered.
REQ-011 SHALL have port busy_o, output, 1: high when a frame is shifting or a byte is pending.

Function
REQ-012 SHALL fully decode a 32-bit address: a write with Address_i==BASE_ADDR and write_enable_i=1 enqueues Write_Data[7:0]; a write to any other address is ignored.
REQ-013 SHALL return {29'b0, full, overrun, busy} on Read_Data_o when Address_i==BASE_ADDR+4, and 0 for all other addresses, including TXDATA.
REQ-014 SHALL clear overrun on a write to BASE_ADDR+4 with Write_Data[1]=1; other STATUS bits are read-only.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, with a baud counter running 0..CLKS_PER_BIT-1 in each non-IDLE state.
REQ-016 IDLE->START occurs at the first edge with a pending byte; that edge pops the byte into the shift register and drives tx_o=0.
REQ-017 Latency: a byte written at edge E0 into an empty queue with an idle FSM SHALL produce tx_o=0 from edge E0+1.
REQ-018 START SHALL last CLKS_PER_BIT cycles, followed by DATA with 8 bits LSB-first, then STOP with tx_o=1, each lasting CLKS_PER_BIT cycles; a frame is 10*CLKS_PER_BIT cycles.
REQ-019 At the end of STOP, if a byte is pending, the FSM SHALL go directly to START with no idle cycle; otherwise it SHALL go to IDLE.
REQ-020 A write on the same edge that the FSM pops the queue SHALL be accepted whenever the queue is full only before the pop.
REQ-021 A write to a full queue SHALL be dropped and set sticky overrun=1, with no change to the queue or FSM.
REQ-022 busy_o SHALL equal (state!=IDLE) OR (queue not empty); full SHALL reflect the queue-full state.

Reset
REQ-023 While reset=1, the block SHALL hold tx_o=1, busy_o=0, overrun=0, queue empty, state=IDLE and baud counter 0, asynchronously, including mid-frame.
REQ-024 The first write after reset deassertion SHALL produce a complete clean frame.

Configuration
REQ-025 With macro UART_TX_FIFO_EN defined, the pending queue SHALL be a 4-entry FIFO, and full means 4 entries.
REQ-026 Without UART_TX_FIFO_EN, the pending queue SHALL be a single holding register, and full means holding valid; all other behaviour is identical.

Structure
REQ-027 Package uart_tx_pkg SHALL hold the FSM state encoding, the register offsets (TXDATA 0, STATUS 4), and the STATUS bit indices (BUSY 0, OVERRUN 1, FULL 2).
REQ-028 The baud counter SHALL be a sub-module uart_baud_counter (clear, enable, terminal-count tick); the remaining logic SHALL be in mmio_uart_tx.

Verification (bench CLKS_PER_BIT=4)
REQ-029 Reset released, no writes -> tx_o=1, busy_o=0, STATUS read returns 0, and a read of 0x1001_0000 returns 0.
REQ-030 Write 0x55 to 0x1001_0000 -> tx_o reads 0 (start) then 1,0,1,0,1,0,1,0 then 1 (stop), each held 4 cycles starting at E0+1; busy_o falls 40 cycles after E0+1.
REQ-031 Writes of 0xA3 then 0x0F on consecutive cycles -> two contiguous 40-cycle frames with no idle gap, and overrun=0.
REQ-032 Overrun: without the FIFO, 3 writes on consecutive cycles -> 3rd dropped and STATUS=0x7 on the next cycle; with the FIFO, 6 writes -> 6th dropped and overrun=1; writing 0x2 to 0x1001_0004 -> overrun=0.
REQ-033 Assert reset during data bit 3 of 0xF0 -> tx_o=1 and busy_o=0 immediately; after release, writing 0x81 yields a correct frame.
REQ-034 Write 0x12 to 0x1001_0008 -> tx_o stays 1, busy_o=0, and the read of 0x1001_0008 returns 0.
